// File: rtl/ntp_sync_ctrl.sv
// -----------------------------------------------------------------------------
// ntp_sync_ctrl
//
// Purpose:
//   Keeps the NTP timestamp counter aligned with the host NTP server. On a
//   resync trigger (the counter's 16 s pulse or a manual request) it asks the
//   network stage to send an NTP client request, then parses the 48-byte NTP
//   reply from the UDP payload stream. The Transmit Timestamp (bytes 40..47)
//   is offset by a fixed path-latency compensation and handed to the counter
//   as a 64-bit load value with a one-cycle load strobe. A missing reply is
//   re-requested up to MAX_RETRY times before the attempt is declared failed.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   i_ntp_sig      16 s pulse from the timestamp counter (resync trigger)
//   i_sync_now     one-cycle manual resync request
//   i_rx_data      UDP payload byte
//   i_rx_valid     i_rx_data carries a byte this cycle
//   i_rx_sof       first payload byte (qualified by i_rx_valid)
//   i_rx_eof       last payload byte (qualified by i_rx_valid)
//   o_ntp_req      one-cycle pulse: send an NTP client request
//   o_ntp_set      timestamp to load into the counter (held between loads)
//   o_ntp_set_sig  one-cycle load strobe for o_ntp_set
//   o_synced       sticky: at least one successful load since reset
//   o_sync_fail    one-cycle pulse: all retries exhausted
//   o_pkt_err      one-cycle pulse: a received packet was rejected
//   o_dbg_state    current FSM state (debug observation only)
//
// Rx stream handshake:
//   A byte is transferred on every cycle in which i_rx_valid is high; there
//   is no ready/backpressure, so this block must accept a byte every cycle.
//   i_rx_sof and i_rx_eof are only meaningful while i_rx_valid is high. A
//   cycle with i_rx_valid low simply stalls the packet.
// -----------------------------------------------------------------------------
module ntp_sync_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [63:0] COMP_FRAC   = 64'd8590
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ntp_sig,
  input  logic        i_sync_now,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_sof,
  input  logic        i_rx_eof,
  output logic        o_ntp_req,
  output logic [63:0] o_ntp_set,
  output logic        o_ntp_set_sig,
  output logic        o_synced,
  output logic        o_sync_fail,
  output logic        o_pkt_err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RX    = 2'd2,
    S_APPLY = 2'd3
  } state_t;

  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
  localparam logic [2:0]  MODE_SERVER = 3'd4;
  localparam logic [5:0]  IDX_MAX     = 6'd63;
  localparam logic [5:0]  IDX_TS_LO   = 6'd40;
  localparam logic [5:0]  IDX_TS_HI   = 6'd47;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      state_q,   state_d;
  logic [5:0]  idx_q,     idx_d;      // index of the last byte received
  logic [7:0]  retry_q,   retry_d;
  logic [31:0] tcnt_q,    tcnt_d;
  logic [2:0]  mode_q,    mode_d;
  logic [7:0]  stratum_q, stratum_d;
  logic [63:0] cap_q,     cap_d;
  logic [63:0] set_q,     set_d;
  logic        synced_q,  synced_d;
  logic        req_q,     req_d;
  logic        set_sig_q, set_sig_d;
  logic        fail_q,    fail_d;
  logic        err_q,     err_d;

  // ---------------------------------------------------------------------------
  // Helper terms for the current byte
  // ---------------------------------------------------------------------------
  logic        rx_sof;
  logic        rx_eof;
  logic        timeout;
  logic [5:0]  idx_inc;
  logic        in_ts;
  logic [63:0] cap_shift;
  logic [63:0] cap_next;
  logic        stratum_ok;
  logic        accept;

  assign rx_sof  = i_rx_valid & i_rx_sof;
  assign rx_eof  = i_rx_valid & i_rx_eof;
  assign timeout = (tcnt_q == TMO_LAST);

  // The index saturates so that an overlong packet can never wrap back
  // round to 47 and be mistaken for a correctly sized reply.
  assign idx_inc = (idx_q == IDX_MAX) ? IDX_MAX : idx_q + 6'd1;

  assign in_ts     = (idx_inc >= IDX_TS_LO) && (idx_inc <= IDX_TS_HI);
  assign cap_shift = {cap_q[55:0], i_rx_data};
  // Capture value including this byte, so the nonzero test on the eof byte
  // sees the complete timestamp.
  assign cap_next  = in_ts ? cap_shift : cap_q;

  assign stratum_ok = (stratum_q != 8'd0) && (stratum_q <= 8'd15);
  assign accept     = (idx_inc == IDX_TS_HI) && (mode_q == MODE_SERVER) &&
                      stratum_ok && (cap_next != 64'd0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      retry_q   <= 8'd0;
      tcnt_q    <= 32'd0;
      mode_q    <= 3'd0;
      stratum_q <= 8'd0;
      cap_q     <= 64'd0;
      set_q     <= 64'd0;
      synced_q  <= 1'b0;
      req_q     <= 1'b0;
      set_sig_q <= 1'b0;
      fail_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      tcnt_q    <= tcnt_d;
      mode_q    <= mode_d;
      stratum_q <= stratum_d;
      cap_q     <= cap_d;
      set_q     <= set_d;
      synced_q  <= synced_d;
      req_q     <= req_d;
      set_sig_q <= set_sig_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    tcnt_d    = tcnt_q;
    mode_d    = mode_q;
    stratum_d = stratum_q;
    cap_d     = cap_q;
    set_d     = set_q;
    synced_d  = synced_q;
    req_d     = 1'b0;
    set_sig_d = 1'b0;
    fail_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_ntp_sig || i_sync_now) begin
          req_d   = 1'b1;
          state_d = S_WAIT;
          tcnt_d  = 32'd0;
          retry_d = 8'd0;
        end
      end

      S_WAIT, S_RX: begin
        tcnt_d = tcnt_q + 32'd1;
        if (timeout) begin
          // Expiry wins over any byte arriving in the same cycle; a packet
          // in flight is abandoned.
          tcnt_d = 32'd0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 8'd1;
            req_d   = 1'b1;
            state_d = S_WAIT;
          end else begin
            fail_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (rx_sof) begin
          // A start byte always opens a fresh packet, discarding any
          // partially received one.
          idx_d     = 6'd0;
          mode_d    = i_rx_data[2:0];
          stratum_d = 8'd0;
          cap_d     = 64'd0;
          if (rx_eof) begin
            err_d   = 1'b1;      // one-byte packet: length error
            state_d = S_WAIT;
          end else begin
            state_d = S_RX;
          end
        end else if ((state_q == S_RX) && i_rx_valid) begin
          idx_d = idx_inc;
          if (idx_inc == 6'd1) begin
            stratum_d = i_rx_data;
          end
          cap_d = cap_next;
          if (rx_eof) begin
            if (accept) begin
              state_d = S_APPLY;
            end else begin
              // The reply window keeps running across a rejected packet.
              err_d   = 1'b1;
              state_d = S_WAIT;
            end
          end
        end
      end

      S_APPLY: begin
        set_d     = cap_q + COMP_FRAC;   // wraps mod 2^64
        set_sig_d = 1'b1;
        synced_d  = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign o_ntp_req     = req_q;
  assign o_ntp_set     = set_q;
  assign o_ntp_set_sig = set_sig_q;
  assign o_synced      = synced_q;
  assign o_sync_fail   = fail_q;
  assign o_pkt_err     = err_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_ntp_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ntp_sync_ctrl
//
// Directed bench for ntp_sync_ctrl. A packet-level reference model (whole
// reply buffered, judged on eof) predicts every output each cycle; literal
// expectations pin key values and timings.
// -----------------------------------------------------------------------------
module tb_ntp_sync_ctrl;

  localparam int unsigned TMO  = 100;
  localparam int unsigned MAXR = 3;
  localparam logic [63:0] COMP = 64'd8590;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        ntp_sig  = 1'b0;
  logic        sync_now = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_sof   = 1'b0;
  logic        rx_eof   = 1'b0;
  logic        ntp_req;
  logic [63:0] ntp_set;
  logic        set_sig;
  logic        synced;
  logic        sync_fail;
  logic        pkt_err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ntp_sync_ctrl #(
    .TIMEOUT_CYC(TMO),
    .MAX_RETRY  (MAXR),
    .COMP_FRAC  (COMP)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ntp_sig    (ntp_sig),
    .i_sync_now   (sync_now),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_rx_sof     (rx_sof),
    .i_rx_eof     (rx_eof),
    .o_ntp_req    (ntp_req),
    .o_ntp_set    (ntp_set),
    .o_ntp_set_sig(set_sig),
    .o_synced     (synced),
    .o_sync_fail  (sync_fail),
    .o_pkt_err    (pkt_err),
    .o_dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int   n_tests  = 0;
  int   n_fail   = 0;
  logic check_en = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks "waiting for a reply", buffers the whole packet,
  // and judges it on eof from its length and field values.
  // ---------------------------------------------------------------------------
  logic        e_req = 1'b0, e_set_sig = 1'b0, e_synced = 1'b0;
  logic        e_fail = 1'b0, e_err = 1'b0;
  logic [63:0] e_set = 64'd0;
  bit          m_wait = 1'b0, m_inpkt = 1'b0, m_apply = 1'b0;
  int          m_elapsed = 0, m_tries = 0;
  logic [63:0] m_apply_val = 64'd0;
  logic [7:0]  m_pkt[$];

  function automatic logic [63:0] m_ts();
    logic [63:0] t = 64'd0;
    for (int i = 40; i < 48; i++) t = {t[55:0], m_pkt[i]};
    return t;
  endfunction

  function automatic bit m_accept();
    if (m_pkt.size() != 48) return 1'b0;
    if (m_pkt[0][2:0] != 3'd4) return 1'b0;
    if (m_pkt[1] == 8'd0 || m_pkt[1] > 8'd15) return 1'b0;
    return (m_ts() != 64'd0);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      e_req = 1'b0; e_fail = 1'b0; e_err = 1'b0; e_set_sig = 1'b0;
      if (rst) begin
        e_set = 64'd0; e_synced = 1'b0;
        m_wait = 1'b0; m_inpkt = 1'b0; m_apply = 1'b0;
        m_pkt.delete();
      end else if (m_apply) begin
        m_apply = 1'b0;
        e_set = m_apply_val; e_set_sig = 1'b1; e_synced = 1'b1;
      end else if (!m_wait) begin
        if (ntp_sig || sync_now) begin
          e_req = 1'b1; m_wait = 1'b1; m_elapsed = 0; m_tries = 0; m_inpkt = 1'b0;
        end
      end else if (m_elapsed == int'(TMO) - 1) begin
        m_elapsed = 0; m_inpkt = 1'b0;
        if (m_tries < int'(MAXR)) begin
          m_tries++; e_req = 1'b1;
        end else begin
          e_fail = 1'b1; m_wait = 1'b0;
        end
      end else begin
        m_elapsed++;
        if (rx_valid) begin
          if (rx_sof) begin
            m_pkt.delete(); m_pkt.push_back(rx_data); m_inpkt = 1'b1;
          end else if (m_inpkt) begin
            m_pkt.push_back(rx_data);
          end
          if (m_inpkt && rx_eof) begin
            m_inpkt = 1'b0;
            if (m_accept()) begin
              m_apply = 1'b1; m_apply_val = m_ts() + COMP; m_wait = 1'b0;
            end else begin
              e_err = 1'b1;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        check1 ("req",       ntp_req,   e_req);
        check1 ("set_sig",   set_sig,   e_set_sig);
        check64("set",       ntp_set,   e_set);
        check1 ("synced",    synced,    e_synced);
        check1 ("sync_fail", sync_fail, e_fail);
        check1 ("pkt_err",   pkt_err,   e_err);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  logic [7:0] tx_q[$];
  int         trig_cyc = 0;

  task automatic pulse_trig(input bit use_sig);
    @(negedge clk);
    if (use_sig) ntp_sig = 1'b1; else sync_now = 1'b1;
    trig_cyc = cyc;
    @(negedge clk);
    ntp_sig = 1'b0; sync_now = 1'b0;
  endtask

  task automatic build_pkt(input logic [7:0] b0, input logic [7:0] strat,
                           input logic [63:0] ts, input int len);
    tx_q.delete();
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      if (i == 0)                 b = b0;
      else if (i == 1)            b = strat;
      else if (i >= 40 && i < 48) b = ts[8*(47-i) +: 8];
      else                        b = 8'(i * 7 + 1);
      tx_q.push_back(b);
    end
  endtask

  // Sends tx_q with one idle (valid-low) cycle before byte 12. rst_at >= 0
  // asserts reset for the cycle carrying that byte.
  task automatic send_pkt(input int rst_at, input bit with_eof, output int eof_cyc);
    eof_cyc = -1;
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clk);
      if (i == 12) begin
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      rx_sof   = (i == 0);
      rx_eof   = with_eof && (i == tx_q.size() - 1);
      rst      = (i == rst_at);
      if (i == tx_q.size() - 1) eof_cyc = cyc;
    end
    @(negedge clk);
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rst = 1'b0;
  endtask

  function automatic logic pick(input int w);
    case (w)
      0:       return ntp_req;
      1:       return set_sig;
      2:       return pkt_err;
      default: return sync_fail;
    endcase
  endfunction

  // Waits (bounded) for a pulse; the final compare fails if it never came.
  task automatic wait_sig(input string name, input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (pick(which)) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    check1(name, pick(which), 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [7:0]  bad_b0[4]    = '{8'h24, 8'h24, 8'h23, 8'h24};
  logic [7:0]  bad_strat[4] = '{8'd2,  8'd2,  8'd2,  8'd0};
  int          bad_len[4]   = '{47, 49, 48, 48};
  int          exp_off[4]   = '{1, 101, 201, 301};

  initial begin
    int tr, te, ts_at, tx, t0, fail_off;
    int offs[$];

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    check64("rst_set",     ntp_set, 64'd0);
    check1 ("rst_req",     ntp_req, 1'b0);
    check1 ("rst_set_sig", set_sig, 1'b0);
    check1 ("rst_synced",  synced,  1'b0);
    check1 ("rst_fail",    sync_fail, 1'b0);
    check1 ("rst_err",     pkt_err, 1'b0);
    check64("rst_state",   64'(dbg_state), 64'd0);
    rst = 1'b0;

    // Basic sync via manual request
    pulse_trig(1'b0);
    wait_sig("req_after_sync", 0, 5, tr);
    check64("req_latency", 64'(tr - trig_cyc), 64'd1);
    build_pkt(8'h24, 8'd2, 64'hE7D0_1234_8000_0000, 48);
    send_pkt(-1, 1'b1, te);
    wait_sig("set_sig_basic", 1, 10, ts_at);
    check64("set_latency", 64'(ts_at - te), 64'd2);
    check64("set_basic",   ntp_set, 64'hE7D0_1234_8000_218E);
    check64("model_basic", e_set,   64'hE7D0_1234_8000_218E);
    check1 ("synced_basic", synced, 1'b1);

    // Wrap of the compensation add, triggered by the 16 s pulse
    pulse_trig(1'b1);
    wait_sig("req_after_sig", 0, 5, tr);
    build_pkt(8'h24, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 48);
    send_pkt(-1, 1'b1, te);
    wait_sig("set_sig_wrap", 1, 10, ts_at);
    check64("set_wrap",   ntp_set, 64'h0000_0000_0000_218D);
    check64("model_wrap", e_set,   64'h0000_0000_0000_218D);

    // Rejections, each followed by a good packet after the retry request
    for (int k = 0; k < 4; k++) begin
      pulse_trig(1'b0);
      wait_sig("req_rej", 0, 5, tr);
      build_pkt(bad_b0[k], bad_strat[k], 64'h0102_0304_0506_0708, bad_len[k]);
      send_pkt(-1, 1'b1, te);
      wait_sig("pkt_err_rej", 2, 5, tx);
      check64("pkt_err_latency", 64'(tx - te), 64'd1);
      wait_sig("retry_req_rej", 0, 150, tr);
      build_pkt(8'h24, 8'd3, 64'h0000_0001_0000_0000, 48);
      send_pkt(-1, 1'b1, te);
      wait_sig("set_sig_after_rej", 1, 10, ts_at);
      check64("set_after_rej", ntp_set, 64'h0000_0001_0000_218E);
    end

    // Partial packet superseded by a fresh sof
    pulse_trig(1'b0);
    wait_sig("req_partial", 0, 5, tr);
    build_pkt(8'h24, 8'd2, 64'hAAAA_AAAA_AAAA_AAAA, 20);
    send_pkt(-1, 1'b0, te);
    build_pkt(8'h24, 8'd2, 64'h1122_3344_5566_7788, 48);
    send_pkt(-1, 1'b1, te);
    wait_sig("set_sig_partial", 1, 10, ts_at);
    check64("set_partial", ntp_set, 64'h1122_3344_5566_9916);

    // No reply: three retries, then failure
    pulse_trig(1'b0);
    t0 = trig_cyc;
    fail_off = -1;
    for (int i = 0; i < 460; i++) begin
      if (ntp_req) offs.push_back(cyc - t0);
      if (sync_fail) begin
        fail_off = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    check1 ("fail_seen",  sync_fail, 1'b1);
    check64("fail_time",  64'(fail_off), 64'd401);
    check64("req_count",  64'(offs.size()), 64'd4);
    for (int i = 0; i < offs.size() && i < 4; i++)
      check64("req_time", 64'(offs[i]), 64'(exp_off[i]));
    check64("state_after_fail", 64'(dbg_state), 64'd0);

    // Reset in the middle of a valid packet
    pulse_trig(1'b0);
    wait_sig("req_rst", 0, 5, tr);
    build_pkt(8'h24, 8'd2, 64'h5555_6666_7777_8888, 48);
    send_pkt(30, 1'b1, te);
    repeat (3) @(negedge clk);
    check64("rst_mid_set",    ntp_set, 64'd0);
    check1 ("rst_mid_synced", synced,  1'b0);
    check64("rst_mid_state",  64'(dbg_state), 64'd0);
    pulse_trig(1'b1);
    wait_sig("req_after_rst", 0, 5, tr);
    check64("req_after_rst_latency", 64'(tr - trig_cyc), 64'd1);
    build_pkt(8'h24, 8'd2, 64'h5555_6666_7777_8888, 48);
    send_pkt(-1, 1'b1, te);
    wait_sig("set_sig_after_rst", 1, 10, ts_at);
    check64("set_after_rst", ntp_set, 64'h5555_6666_7777_AA16);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ntp_sync_ctrl.md
Name: ntp_sync_ctrl

Overview:
- Upstream feeder of the NTP timestamp counter: requests time from the host NTP server and parses the 48-byte NTP reply from the UDP payload byte stream.
- Extracts the Transmit Timestamp and adds a fixed path-latency compensation.
- Drives the counter's 64-bit load value together with a one-cycle load strobe.
- A resync is triggered by the counter's 16 s pulse or by a manual request. Timeout and retry are handled internally.

Parameters:
TIMEOUT_CYC, 50_000_000, reply wait per attempt in i_clk cycles (1 s at 50 MHz)
MAX_RETRY, 3, request re-issues after first timeout before declaring failure
COMP_FRAC, 8590, 64-bit constant added to the received timestamp (2 us, in units of 2^-32 s)

Ports:
i_clk  in  1  system clock, 50 MHz
i_rst  in  1  synchronous, active-high reset
i_ntp_sig  in  1  16 s pulse from the timestamp counter; triggers a resync
i_sync_now  in  1  one-cycle manual resync request
i_rx_data  in  8  UDP payload byte
i_rx_valid  in  1  i_rx_data is valid this cycle
i_rx_sof  in  1  first payload byte; qualified by i_rx_valid
i_rx_eof  in  1  last payload byte; qualified by i_rx_valid
o_ntp_req  out  1  one-cycle pulse asking the network stage to send an NTP client request
o_ntp_set  out  64  timestamp to load into the counter
o_ntp_set_sig  out  1  one-cycle load strobe for o_ntp_set
o_synced  out  1  high after at least one successful load
o_sync_fail  out  1  one-cycle pulse when retries are exhausted
o_pkt_err  out  1  one-cycle pulse when a received packet is rejected

Behaviour:
- Reset values: all outputs 0. State is S_IDLE; byte index, retry count and timeout count are 0.
- Reset has priority over all other inputs. Reset mid-packet discards the packet. o_synced clears.
- S_IDLE:
  - i_ntp_sig or i_sync_now in a cycle → o_ntp_req=1 next cycle; go to S_WAIT; clear timeout count and retry count.
  - rx traffic is ignored.
- S_WAIT:
  - i_rx_valid & i_rx_sof → capture byte 0 as index 0; go to S_RX.
  - Timeout count increments each cycle. At TIMEOUT_CYC-1:
    - if retry < MAX_RETRY: retry+1, re-pulse o_ntp_req, clear the count.
    - else: pulse o_sync_fail; go to S_IDLE.
  - i_ntp_sig and i_sync_now are ignored in S_WAIT and S_RX.
- S_RX:
  - Each valid byte increments the byte index; the index saturates at 63.
  - Byte 0 bits[2:0] hold the mode. Byte 1 holds the stratum.
  - Bytes 40..47 are shifted MSB-first into a 64-bit capture register.
  - Bytes after index 47 are not captured.
  - The timeout count keeps running; on expiry, handle as in S_WAIT and drop the packet.
  - i_rx_valid & i_rx_sof mid-packet → restart at index 0 and discard the partial packet.
- On the eof byte, the packet is accepted only if all of these hold:
  - the eof byte index is 47;
  - mode == 4;
  - stratum is 1..15;
  - the captured timestamp is nonzero.
- eof outcome:
  - Accept → S_APPLY.
  - Reject → pulse o_pkt_err; return to S_WAIT without resetting the timeout count.
- S_APPLY (1 cycle):
  - o_ntp_set = capture + COMP_FRAC, computed mod 2^64. The value is registered and held until the next load.
  - o_ntp_set_sig=1 for exactly one cycle.
  - o_synced=1 (sticky until reset).
  - Go to S_IDLE.
- Latency: o_ntp_set_sig is asserted 2 cycles after the eof byte cycle.
- A single-byte packet with sof=eof=1 is rejected as a length error.
- i_rx_valid low mid-packet: the packet stalls, with no error.

Test Plan:
- i_sync_now pulse → o_ntp_req one cycle later. Feed a valid 48-byte reply with byte0=0x24, stratum 2, bytes40..47=0x E7D0_1234_8000_0000 → o_ntp_set=0xE7D0_1234_8000_218E, o_ntp_set_sig high 1 cycle, 2 cycles after eof; o_synced=1.
- Transmit timestamp 0xFFFF_FFFF_FFFF_FFFF → o_ntp_set=0x0000_0000_0000_218D (wrap).
- No reply, with TIMEOUT_CYC=100 → o_ntp_req pulses at t=1, ~101, ~201, ~301; o_sync_fail at ~401; state S_IDLE; no o_ntp_set_sig.
- Rejections, each → o_pkt_err; no set strobe; next valid packet accepted:
  - 47-byte packet;
  - 49-byte packet;
  - mode=3;
  - stratum=0.
- Partial packet of 20 bytes, then a new sof with a valid 48-byte packet → accepted; the timestamp comes from the second packet only.
- i_rst asserted at byte 30 of a valid packet → all outputs 0; remainder of the packet ignored (S_IDLE); i_ntp_sig afterwards starts a new request.
